// File: rtl/axilite_pkg.sv
// axilite_pkg: response codes, FSM states and address helpers for the AXI-Lite native bridge
package axilite_pkg;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [1:0]  RESP_DECERR  = 2'b11;
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

    // 33-bit compare so a window touching 32'hFFFF_FFFF does not wrap
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] span);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < ({1'b0, base} + {1'b0, span}));
    endfunction

    // word-aligned offset into the decoded window
    function automatic logic [31:0] offset(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/native_req_tracker.sv
// native_req_tracker: holds a native EN level and ends it on ack or after TIMEOUT_CYCLES
module native_req_tracker #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic ack,
    input  logic err,
    output logic en,
    output logic done,
    output logic slverr,
    output logic timed_out
);

    logic [15:0] cnt;
    logic        last;

    assign last      = cnt == 16'(TIMEOUT_CYCLES - 1);
    assign done      = en && (ack || last);
    assign timed_out = en && !ack && last;
    assign slverr    = !ack || err;

    // EN rises on start, drops on completion; counter counts EN-high cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en  <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            en  <= 1'b1;
            cnt <= '0;
        end else if (done) begin
            en  <= 1'b0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/axilite_slave_native_bridge_32x32.sv
// axilite_slave_native_bridge_32x32: AXI4-Lite slave terminating into a native req/ack register bus
module axilite_slave_native_bridge_32x32
    import axilite_pkg::*;
#(
    parameter int          C_AXI_DATA_WIDTH = 32,
    parameter int          C_AXI_ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR        = 32'h0001_0000,
    parameter logic [31:0] ADDR_SPAN        = 32'h0001_0000,
    parameter int          TIMEOUT_CYCLES   = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          WR_EN,
    output logic [C_AXI_ADDR_WIDTH-1:0]   WR_ADDR,
    output logic [C_AXI_DATA_WIDTH-1:0]   WR_DATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] WR_STRB,
    input  logic                          WR_ACK,
    input  logic                          WR_ERR,
    output logic                          RD_EN,
    output logic [C_AXI_ADDR_WIDTH-1:0]   RD_ADDR,
    input  logic [C_AXI_DATA_WIDTH-1:0]   RD_DATA,
    input  logic                          RD_ACK,
    input  logic                          RD_ERR
);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;
    logic      up;
    logic      aw_latched, w_latched, aw_ok;
    logic      aw_hs, w_hs, aw_have, w_have, aw_ok_cur, w_fire, w_start;
    logic      ar_hs, ar_ok, r_start;
    logic      wr_done, wr_slverr, unused_wr_timeout;
    logic      rd_done, rd_slverr, rd_timed_out;
    logic      unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // READY is held low until the first clock after reset releases
    assign S_AXI_AWREADY = up && w_state == W_IDLE && !aw_latched;
    assign S_AXI_WREADY  = up && w_state == W_IDLE && !w_latched;
    assign S_AXI_ARREADY = up && r_state == R_IDLE;
    assign S_AXI_BVALID  = w_state == W_RESP;
    assign S_AXI_RVALID  = r_state == R_RESP;

    assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
    assign aw_have   = aw_latched || aw_hs;
    assign w_have    = w_latched || w_hs;
    assign aw_ok_cur = aw_latched ? aw_ok : in_range(S_AXI_AWADDR, BASE_ADDR, ADDR_SPAN);
    assign w_fire    = aw_have && w_have;
    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_ok     = in_range(S_AXI_ARADDR, BASE_ADDR, ADDR_SPAN);

    native_req_tracker #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_tracker (
        .clock     (clock),
        .reset     (reset),
        .start     (w_start),
        .ack       (WR_ACK),
        .err       (WR_ERR),
        .en        (WR_EN),
        .done      (wr_done),
        .slverr    (wr_slverr),
        .timed_out (unused_wr_timeout)
    );

    native_req_tracker #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_tracker (
        .clock     (clock),
        .reset     (reset),
        .start     (r_start),
        .ack       (RD_ACK),
        .err       (RD_ERR),
        .en        (RD_EN),
        .done      (rd_done),
        .slverr    (rd_slverr),
        .timed_out (rd_timed_out)
    );

    // state registers and the post-reset ready enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            up      <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            up      <= 1'b1;
        end
    end

    // write FSM: fire once both AW and W are held, skip the native bus on decode miss
    always_comb begin
        w_next  = w_state;
        w_start = 1'b0;
        case (w_state)
            W_IDLE: begin
                w_start = w_fire && aw_ok_cur;
                w_next  = w_fire ? (aw_ok_cur ? W_WAIT : W_RESP) : W_IDLE;
            end
            W_WAIT:  w_next = wr_done ? W_RESP : W_WAIT;
            W_RESP:  w_next = S_AXI_BREADY ? W_IDLE : W_RESP;
            default: w_next = W_IDLE;
        endcase
    end

    // read FSM: single AR handshake, then native request or immediate DECERR
    always_comb begin
        r_next  = r_state;
        r_start = 1'b0;
        case (r_state)
            R_IDLE: begin
                r_start = ar_hs && ar_ok;
                r_next  = ar_hs ? (ar_ok ? R_WAIT : R_RESP) : R_IDLE;
            end
            R_WAIT:  r_next = rd_done ? R_RESP : R_WAIT;
            R_RESP:  r_next = S_AXI_RREADY ? R_IDLE : R_RESP;
            default: r_next = R_IDLE;
        endcase
    end

    // write datapath: independent AW/W latches, native request fields and BRESP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_latched  <= 1'b0;
            w_latched   <= 1'b0;
            aw_ok       <= 1'b0;
            WR_ADDR     <= '0;
            WR_DATA     <= '0;
            WR_STRB     <= '0;
            S_AXI_BRESP <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_latched <= 1'b1;
                aw_ok      <= aw_ok_cur;
                WR_ADDR    <= offset(S_AXI_AWADDR, BASE_ADDR);
            end
            if (w_hs) begin
                w_latched <= 1'b1;
                WR_DATA   <= S_AXI_WDATA;
                WR_STRB   <= S_AXI_WSTRB;
            end
            if (w_state == W_IDLE && w_fire && !aw_ok_cur)
                S_AXI_BRESP <= RESP_DECERR;
            if (w_state == W_WAIT && wr_done)
                S_AXI_BRESP <= wr_slverr ? RESP_SLVERR : RESP_OKAY;
            if (w_state == W_RESP && S_AXI_BREADY) begin
                aw_latched <= 1'b0;
                w_latched  <= 1'b0;
            end
        end
    end

    // read datapath: native address, captured data or filler, and RRESP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RD_ADDR     <= '0;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else begin
            if (ar_hs)
                RD_ADDR <= offset(S_AXI_ARADDR, BASE_ADDR);
            if (ar_hs && !ar_ok) begin
                S_AXI_RDATA <= '0;
                S_AXI_RRESP <= RESP_DECERR;
            end
            if (r_state == R_WAIT && rd_done) begin
                S_AXI_RDATA <= rd_timed_out ? TIMEOUT_FILL : RD_DATA;
                S_AXI_RRESP <= rd_slverr ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: doc/axilite_slave_native_bridge_32x32.md
# axilite_slave_native_bridge_32x32

AXI4-Lite slave that terminates transactions from a 32-bit AXI-Lite initiator and converts them into a simple native register request/acknowledge bus for user logic. It is the responder counterpart of the AXI-Lite master's W_EN/R_EN control interface. It sits between the AXI-Lite interconnect and peripheral register banks that need variable-latency access. Write and read paths are independent, and each path has address decoding and a timeout.

## Interface
- C_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 32, address width.
- BASE_ADDR, 32'h0001_0000, first decoded byte address.
- ADDR_SPAN, 32'h0001_0000, decoded window size in bytes; must be a power of two.
- TIMEOUT_CYCLES, 255, maximum number of EN-high cycles before the bridge gives up; range 1..65535.
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  32/3/1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR/ARPROT/ARVALID  in  32/3/1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- WR_EN  out  1  write request, a level held until acknowledged or timed out.
- WR_ADDR  out  32  offset (addr − BASE_ADDR) with bits [1:0] forced to 0.
- WR_DATA/WR_STRB  out  32/4  write data and byte strobes.
- WR_ACK, WR_ERR  in  1/1  completion and error flag; both sampled in the same cycle.
- RD_EN  out  1; RD_ADDR  out  32  same rules as the write path.
- RD_DATA  in  32; RD_ACK, RD_ERR  in  1/1.

## Operation
- Write FSM states:
  - W_IDLE: AWREADY=!aw_latched, WREADY=!w_latched. AW and W are accepted in either order or in the same cycle, and each is latched independently.
  - When both are latched: in-range → W_WAIT; out-of-range → W_RESP with DECERR, and WR_EN is never raised.
  - W_WAIT: WR_EN=1; the timeout counter increments every cycle.
    - WR_ACK=1 → BRESP=ERR?SLVERR:OKAY, go to W_RESP.
    - Counter reaches TIMEOUT_CYCLES → BRESP=SLVERR, go to W_RESP.
  - W_RESP: BVALID=1 and BRESP stable until BREADY; then return to W_IDLE and clear the latches.
- Read FSM states:
  - R_IDLE: ARREADY=1; the AR handshake goes to R_WAIT (in range) or R_RESP (DECERR, RDATA=0).
  - R_WAIT: RD_EN=1; RD_ACK captures RD_DATA into RDATA, with RRESP=ERR?SLVERR:OKAY. On timeout: SLVERR, RDATA=32'hDEAD_DEAD.
  - R_RESP: RVALID=1 and data stable until RREADY; then return to R_IDLE.
- Address decode: in range iff BASE_ADDR ≤ addr < BASE_ADDR+ADDR_SPAN. The comparison uses 33-bit arithmetic so there is no wrap at 32'hFFFF_FFFF.
- AWPROT and ARPROT are ignored.
- Write and read paths run concurrently with no ordering between them. User logic resolves same-address hazards.
- ACK or ERR asserted while the matching EN is low is ignored.

## Timing
- Reset values: all READY, VALID and EN outputs are 0; BRESP=RRESP=0; RDATA=0; WR_*/RD_* address, data and strobe are 0; FSMs are idle; latches and counters are cleared.
- The first READY goes high in the cycle after reset deasserts.
- Write latency, with AW+W handshaken in cycle 0 and ACK held high:
  - WR_EN=1 in cycle 1.
  - BVALID=1 in cycle 2.
  - The next AW/W can be accepted the cycle after the B handshake.
- Read latency, with the AR handshake in cycle 0 and ACK held high: RD_EN=1 in cycle 1, RVALID=1 in cycle 2.
- Timeout: EN stays high for exactly TIMEOUT_CYCLES cycles. VALID rises the next cycle.
- An ACK arriving in the final timeout cycle wins over the timeout.
- DECERR: VALID rises one cycle after the address and data are complete.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). The pending response is lost.

## Structure
- Package axilite_pkg holds:
  - Response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enums for the write and read FSMs.
  - Timeout filler constant 32'hDEAD_DEAD.
- Sub-module native_req_tracker is instantiated once per path. It holds the EN level, the timeout counter, and the ack/err/timeout result.

## Test plan
- Reset: read 0x10000 with an ack responder → RDATA=0x00000000, RRESP=OKAY. All outputs are 0 during reset.
- Write 0x14000 with 0xDEADBEEF, strobe 0xF; responder acks 3 cycles late → WR_ADDR=0x4000, WR_DATA=0xDEADBEEF, BRESP=OKAY. A following read with RD_DATA=0xDEADBEEF returns 0xDEADBEEF.
- W presented 2 cycles before AW, then AW and W presented in the same cycle → both produce exactly one WR_EN request, BRESP=OKAY.
- Access 0x20000 (out of range) → BRESP=DECERR and RRESP=DECERR, RDATA=0; WR_EN and RD_EN never assert.
- Responder never acks, TIMEOUT_CYCLES=8 → EN high for 8 cycles, then SLVERR (read data 0xDEADDEAD). RD_ERR=1 with ack → SLVERR.
- Concurrent write and read, with BREADY held low for 5 cycles → BVALID and BRESP stay stable. Reset asserted in W_WAIT → WR_EN=0 and BVALID=0 immediately; a fresh transaction afterwards completes OKAY.
